// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider returning {remainder, quotient} for DIV/DIVU.
// Optional abort input annul_i is built only when DIV_ANNUL_EN is defined.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
`ifdef DIV_ANNUL_EN
  input  logic               annul_i,
`endif
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  // dvd_reg shifts the dividend out at the top while quotient bits enter at the bottom
  logic [WIDTH-1:0]   dvd_reg, dvd_next;
  logic [WIDTH-1:0]   dvs_reg, dvs_next;
  logic [WIDTH-1:0]   rem_reg, rem_next;
  logic               sgn_reg, sgn_next;
  logic               neg1_reg, neg1_next;
  logic               neg2_reg, neg2_next;
  logic [2*WIDTH-1:0] result_reg, result_next;
  logic               ready_reg, ready_next;

  logic               flush;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH-1:0]   rem_shift;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

`ifdef DIV_ANNUL_EN
  assign flush = annul_i;
`else
  assign flush = 1'b0;
`endif

  assign abs1 = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
  assign abs2 = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

  assign rem_shift = {rem_reg[WIDTH-2:0], dvd_reg[WIDTH-1]};
  assign diff      = {1'b0, rem_shift} - {1'b0, dvs_reg};

  // Remainder follows the dividend sign, quotient is negative when the signs differ
  assign quo_fix = (sgn_reg && (neg1_reg ^ neg2_reg)) ? (~dvd_reg + 1'b1) : dvd_reg;
  assign rem_fix = (sgn_reg && neg1_reg) ? (~rem_reg + 1'b1) : rem_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= S_FREE;
      cnt_reg    <= '0;
      dvd_reg    <= '0;
      dvs_reg    <= '0;
      rem_reg    <= '0;
      sgn_reg    <= 1'b0;
      neg1_reg   <= 1'b0;
      neg2_reg   <= 1'b0;
      result_reg <= '0;
      ready_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      dvd_reg    <= dvd_next;
      dvs_reg    <= dvs_next;
      rem_reg    <= rem_next;
      sgn_reg    <= sgn_next;
      neg1_reg   <= neg1_next;
      neg2_reg   <= neg2_next;
      result_reg <= result_next;
      ready_reg  <= ready_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    dvd_next    = dvd_reg;
    dvs_next    = dvs_reg;
    rem_next    = rem_reg;
    sgn_next    = sgn_reg;
    neg1_next   = neg1_reg;
    neg2_next   = neg2_reg;
    result_next = result_reg;
    ready_next  = ready_reg;

    case (state_reg)
      S_FREE: begin
        ready_next  = 1'b0;
        result_next = '0;
        if (start_i) begin
          if (opdata2_i == '0) begin
            state_next = S_BYZERO;
          end else begin
            state_next = S_ON;
            cnt_next   = '0;
            dvd_next   = abs1;
            dvs_next   = abs2;
            rem_next   = '0;
            sgn_next   = signed_div_i;
            neg1_next  = opdata1_i[WIDTH-1];
            neg2_next  = opdata2_i[WIDTH-1];
          end
        end
      end

      S_BYZERO: begin
        state_next  = S_END;
        result_next = '0;
        ready_next  = 1'b1;
      end

      S_ON: begin
        if (!start_i) begin
          state_next  = S_FREE;
          ready_next  = 1'b0;
          result_next = '0;
        end else if (cnt_reg != CNT_LAST) begin
          cnt_next = cnt_reg + CNT_ONE;
          if (diff[WIDTH]) begin
            rem_next = rem_shift;
            dvd_next = {dvd_reg[WIDTH-2:0], 1'b0};
          end else begin
            rem_next = diff[WIDTH-1:0];
            dvd_next = {dvd_reg[WIDTH-2:0], 1'b1};
          end
        end else begin
          state_next  = S_END;
          result_next = {rem_fix, quo_fix};
          ready_next  = 1'b1;
        end
      end

      S_END: begin
        if (!start_i) begin
          state_next  = S_FREE;
          ready_next  = 1'b0;
          result_next = '0;
        end
      end

      default: begin
        state_next  = S_FREE;
        ready_next  = 1'b0;
        result_next = '0;
      end
    endcase

    if (flush) begin
      state_next  = S_FREE;
      ready_next  = 1'b0;
      result_next = '0;
    end
  end

  assign result_o = result_reg;
  assign ready_o  = ready_reg;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed vector table, corner sequences and random ops vs. a 64-bit arithmetic model.
// Annul sequences are compiled when DIV_ANNUL_EN is defined.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
`ifdef DIV_ANNUL_EN
  logic        annul_i = 1'b0;
`endif
  logic [63:0] result_o;
  logic        ready_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i),
    .opdata2_i(opdata2_i),
    .start_i(start_i),
`ifdef DIV_ANNUL_EN
    .annul_i(annul_i),
`endif
    .result_o(result_o),
    .ready_o(ready_o)
  );

  typedef struct {
    string       name;
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
    int          exp_lat;
  } vec_t;

  // Reference: exact division on 64-bit integers, then wrap to 32 bits.
  function automatic logic [63:0] ref_div(bit s, logic [31:0] a, logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  task automatic do_op(input string name, input bit s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp_res, input int exp_lat);
    int lat;
    bit held;
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!ready_o && lat < 200);
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " result"}, result_o, exp_res);
    @(negedge clk);
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = ~s;
    held = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (!ready_o || result_o !== exp_res) held = 1'b0;
    end
    check({name, " hold"}, 64'(held), 64'd1);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({name, " clear"}, {result_o[62:0], ready_o}, 64'd0);
  endtask

  initial begin
    vec_t vecs[7];
    vecs[0] = '{"divu_100_7",   1'b0, 32'd100,        32'd7,        32'd14,       32'd2,        33};
    vecs[1] = '{"div_m7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 33};
    vecs[2] = '{"div_7_m2",     1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        33};
    vecs[3] = '{"div_5_0",      1'b1, 32'd5,          32'd0,        32'd0,        32'd0,        1};
    vecs[4] = '{"div_min_m1",   1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,       33};
    vecs[5] = '{"divu_max_1",   1'b0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'd0,        33};
    vecs[6] = '{"divu_9_3",     1'b0, 32'd9,          32'd3,        32'd3,        32'd0,        33};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", {result_o[62:0], ready_o}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("after release", {result_o[62:0], ready_o}, 64'd0);

    foreach (vecs[i]) begin
      do_op(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b,
            {vecs[i].exp_r, vecs[i].exp_q}, vecs[i].exp_lat);
    end

    // Abort by dropping start after 10 iterations
    begin
      bit quiet;
      @(negedge clk);
      signed_div_i = 1'b0;
      opdata1_i = 32'd1000;
      opdata2_i = 32'd3;
      start_i = 1'b1;
      @(posedge clk);
      repeat (10) @(posedge clk);
      @(negedge clk);
      start_i = 1'b0;
      quiet = 1'b1;
      repeat (40) begin
        @(posedge clk);
        #1;
        if (ready_o || result_o !== 64'd0) quiet = 1'b0;
      end
      check("abort quiet", 64'(quiet), 64'd1);
      do_op("after_abort_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);
    end

    // Reset during ON, then during END
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i = 32'd77;
    opdata2_i = 32'd5;
    start_i = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst mid on", {result_o[62:0], ready_o}, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("rst mid on later", {result_o[62:0], ready_o}, 64'd0);

    @(negedge clk);
    opdata1_i = 32'd77;
    opdata2_i = 32'd5;
    start_i = 1'b1;
    repeat (35) @(posedge clk);
    #1;
    check("pre rst end", result_o, {32'd2, 32'd15});
    #2;
    rst = 1'b0;
    #1;
    check("rst in end", {result_o[62:0], ready_o}, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    rst = 1'b1;

`ifdef DIV_ANNUL_EN
    // Annul in END
    @(negedge clk);
    signed_div_i = 1'b1;
    opdata1_i = 32'hFFFF_FFF9;
    opdata2_i = 32'd2;
    start_i = 1'b1;
    repeat (35) @(posedge clk);
    #1;
    check("annul pre", {63'd0, ready_o}, 64'd1);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    check("annul in end", {result_o[62:0], ready_o}, 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;

    // Annul and start together in FREE: nothing starts until annul drops
    begin
      int lat;
      @(negedge clk);
      annul_i = 1'b1;
      signed_div_i = 1'b0;
      opdata1_i = 32'd100;
      opdata2_i = 32'd7;
      start_i = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check("annul+start free", {result_o[62:0], ready_o}, 64'd0);
      @(negedge clk);
      annul_i = 1'b0;
      @(posedge clk);
      lat = 0;
      do begin
        @(posedge clk);
        #1;
        lat++;
      end while (!ready_o && lat < 200);
      check("post annul latency", 64'(lat), 64'd33);
      check("post annul result", result_o, {32'd2, 32'd14});
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk);
    end
`endif

    // Randomized operations against the model
    for (int n = 0; n < 30; n++) begin
      bit          s;
      logic [31:0] a, b;
      s = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'd0 - 32'($urandom_range(1, 300));
        default: b = $urandom;
      endcase
      do_op($sformatf("rnd%0d s=%0d %h/%h", n, s, a, b), s, a, b, ref_div(s, a, b),
            (b == 32'd0) ? 1 : 33);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
